pll_reset_sequencer: RTL and testbench

Reset and lock controller for the board clock PLL, running on the free-running 50 MHz `clkin`. It pulses the PLL's `rst` input and waits for `locked` with a timeout and retry. It qualifies lock over a stability window, then releases per-domain resets (m25/m100/m50/m106/m75) one at a time. On loss of lock it forces every domain back into reset and relocks. Each consuming domain resynchronizes its `dom_rst` bit locally.

---
 rtl/pll_seq_pkg.sv | 27 ++
 rtl/pll_lock_sync.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state codes (also the
// debug `state` output), retry counter width, and a small max helper used to
// size the shared phase counter.
package pll_seq_pkg;

  // Encodings are fixed because they double as the externally visible debug code.
  typedef enum logic [2:0] {
    ST_PLLRST  = 3'd0,
    ST_WAIT    = 3'd1,
    ST_STABLE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_FAULT   = 3'd5
  } pll_state_e;

  localparam int RETRY_W = 4;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL `locked` flag into the clkin domain.
// Latency: 2 clkin edges from input sample to sync_o. No backpressure.
// Ports: clk_i (clkin), clr_i (sync active-high clear), async_i (raw lock),
//        sync_o (synchronized lock).
module pll_lock_sync (
  input  logic clk_i,
  input  logic clr_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock controller: pulses pll_rst, waits for lock with timeout and
// retry, qualifies lock over a stability window, then releases per-domain
// resets one at a time; lock loss forces all domains back into reset.
// Latency: lock seen 2 edges after `locked` sampled; all outputs registered.
// Backpressure: none; free-running on clkin.
// Ports: clkin, rst (sync active-high), locked (async) in;
//        pll_rst, dom_rst[DOMAINS], ready, retries[4], fault, state[3] out.
// Optional feature: define PLLSEQ_FAULT_EN to stop in FAULT after MAX_RETRY
// timeouts; otherwise retries are unbounded and fault is tied 0.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGGER       = 8,
  parameter int DOMAINS       = 5,
  parameter int MAX_RETRY     = 7
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               locked,
  output logic               pll_rst,
  output logic [DOMAINS-1:0] dom_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retries,
  output logic               fault,
  output logic [2:0]         state
);

  localparam int CNT_MAX = max_of4(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGGER);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // PLLRST counts one extra step so that pll_rst falls exactly RST_CYCLES
  // edges after rst is released (the reset edge itself loads count 0).
  localparam logic [CNT_W-1:0] RST_END    = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_END   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_END   = CNT_W'(STAGGER - 1);
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  logic lk;

  pll_lock_sync u_sync (
    .clk_i   (clkin),
    .clr_i   (rst),
    .async_i (locked),
    .sync_o  (lk)
  );

  pll_state_e         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               pll_rst_q, pll_rst_d;
  logic [DOMAINS-1:0] dom_q,     dom_d;
  logic               ready_q,   ready_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic [RETRY_W-1:0] retry_inc;
`ifdef PLLSEQ_FAULT_EN
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  logic               fault_q,   fault_d;
`endif

  assign retry_inc = (retries_q == RETRY_SAT) ? retries_q : retries_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    pll_rst_d = pll_rst_q;
    dom_d     = dom_q;
    ready_d   = ready_q;
    retries_d = retries_q;
`ifdef PLLSEQ_FAULT_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      ST_PLLRST: begin
        pll_rst_d = 1'b1;
        if (cnt_q == RST_END) begin
          state_d   = ST_WAIT;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end
      end
      ST_WAIT: begin
        // Lock is tested before the timeout so a coincident lock wins.
        if (lk) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_END) begin
          state_d   = ST_PLLRST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          retries_d = retry_inc;
`ifdef PLLSEQ_FAULT_EN
          if (retry_inc == RETRY_LIMIT) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end
`endif
        end
      end
      ST_STABLE, ST_RELEASE: begin
        if (!lk) begin
          // A dropout while only qualifying just restarts the wait; once any
          // domain has been released it needs a full PLL reset.
          cnt_d = '0;
          if (state_q == ST_STABLE) begin
            state_d = ST_WAIT;
          end else begin
            state_d   = ST_PLLRST;
            pll_rst_d = 1'b1;
            dom_d     = '1;
            ready_d   = 1'b0;
          end
        end else if ((state_q == ST_STABLE  && cnt_q == STABLE_END) ||
                     (state_q == ST_RELEASE && cnt_q == STAG_END)) begin
          // Shifting in zeros releases domains strictly in index order.
          cnt_d = '0;
          dom_d = dom_q << 1;
          if (dom_d == '0) begin
            state_d   = ST_RUN;
            ready_d   = 1'b1;
            retries_d = '0;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lk) begin
          state_d   = ST_PLLRST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          dom_d     = '1;
          ready_d   = 1'b0;
        end
      end
`ifdef PLLSEQ_FAULT_EN
      ST_FAULT: begin
        cnt_d = cnt_q;
      end
`endif
      default: begin
        state_d   = ST_PLLRST;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
        dom_d     = '1;
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q   <= ST_PLLRST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      retries_q <= '0;
`ifdef PLLSEQ_FAULT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      retries_q <= retries_d;
`ifdef PLLSEQ_FAULT_EN
      fault_q   <= fault_d;
`endif
    end
  end

  assign pll_rst = pll_rst_q;
  assign dom_rst = dom_q;
  assign ready   = ready_q;
  assign retries = retries_q;
  assign state   = state_q;
`ifdef PLLSEQ_FAULT_EN
  assign fault   = fault_q;
`else
  assign fault   = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  logic       clkin;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic [4:0] dom_rst;
  logic       ready;
  logic [3:0] retries;
  logic       fault;
  logic [2:0] state;

  int n_chk;
  int n_fail;
  int e;
  int w;

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .STAGGER       (2),
    .DOMAINS       (5),
    .MAX_RETRY     (3)
  ) dut (
    .clkin   (clkin),
    .rst     (rst),
    .locked  (locked),
    .pll_rst (pll_rst),
    .dom_rst (dom_rst),
    .ready   (ready),
    .retries (retries),
    .fault   (fault),
    .state   (state)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, act, exp);
    end
  endtask

  // Advance one clock edge and sample 1 ns later.
  task automatic tick();
    @(posedge clkin);
    #1;
    e++;
  endtask

  task automatic go_to(input int t);
    while (e < t) tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    e      = 0;
    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) tick();

    chk_eq("rst_pll_rst", pll_rst, 1);
    chk_eq("rst_dom", dom_rst, 5'h1f);
    chk_eq("rst_ready", ready, 0);
    chk_eq("rst_retries", retries, 0);
    chk_eq("rst_fault", fault, 0);
    chk_eq("rst_state", state, 0);

    // Clean lock: rst released, first low sample is edge 0.
    rst = 1'b0;
    e   = -1;
    go_to(3);  chk_eq("clean_pll_rst_e3", pll_rst, 1);
    go_to(4);  chk_eq("clean_pll_rst_e4", pll_rst, 0);
               chk_eq("clean_state_e4", state, 1);
    go_to(9);  locked = 1'b1;
    go_to(11); chk_eq("clean_state_e11", state, 1);
    go_to(12); chk_eq("clean_state_e12", state, 2);
    go_to(19); chk_eq("clean_dom_e19", dom_rst, 5'h1f);
    go_to(20); chk_eq("clean_dom_e20", dom_rst, 5'h1e);
               chk_eq("clean_state_e20", state, 3);
    go_to(21); chk_eq("clean_dom_e21", dom_rst, 5'h1e);
    go_to(22); chk_eq("clean_dom_e22", dom_rst, 5'h1c);
    go_to(24); chk_eq("clean_dom_e24", dom_rst, 5'h18);
    go_to(26); chk_eq("clean_dom_e26", dom_rst, 5'h10);
               chk_eq("clean_ready_e26", ready, 0);
    go_to(28); chk_eq("clean_dom_e28", dom_rst, 5'h00);
               chk_eq("clean_ready_e28", ready, 1);
               chk_eq("clean_state_e28", state, 4);
               chk_eq("clean_retries_e28", retries, 0);

    // Lock loss in RUN: locked sampled low at edge 40.
    go_to(39); locked = 1'b0;
    go_to(41); chk_eq("loss_dom_e41", dom_rst, 5'h00);
               chk_eq("loss_ready_e41", ready, 1);
    go_to(42); chk_eq("loss_dom_e42", dom_rst, 5'h1f);
               chk_eq("loss_ready_e42", ready, 0);
               chk_eq("loss_pll_rst_e42", pll_rst, 1);
               chk_eq("loss_state_e42", state, 0);
               chk_eq("loss_retries_e42", retries, 0);

    // Relock: lock raised as soon as WAIT is entered, sampled at w+1.
    for (int i = 0; i < 50 && pll_rst; i++) tick();
    chk_eq("relock_pll_rst_low", pll_rst, 0);
    w = e;
    locked = 1'b1;
    go_to(w + 2);  chk_eq("relock_state_w2", state, 1);
    go_to(w + 3);  chk_eq("relock_state_w3", state, 2);
    go_to(w + 10); chk_eq("relock_dom_w10", dom_rst, 5'h1f);
    go_to(w + 11); chk_eq("relock_dom_w11", dom_rst, 5'h1e);
    go_to(w + 18); chk_eq("relock_dom_w18", dom_rst, 5'h10);
                   chk_eq("relock_ready_w18", ready, 0);
    go_to(w + 19); chk_eq("relock_dom_w19", dom_rst, 5'h00);
                   chk_eq("relock_ready_w19", ready, 1);

    // Glitch in STABLE: locked low for samples at edges 15 and 16.
    locked = 1'b0;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    e   = -1;
    go_to(9);  locked = 1'b1;
    go_to(14); locked = 1'b0;
    go_to(16); chk_eq("glitch_state_e16", state, 2);
               locked = 1'b1;
    go_to(17); chk_eq("glitch_state_e17", state, 1);
               chk_eq("glitch_retries_e17", retries, 0);
    go_to(18); chk_eq("glitch_state_e18", state, 1);
    go_to(19); chk_eq("glitch_state_e19", state, 2);
    go_to(26); chk_eq("glitch_dom_e26", dom_rst, 5'h1f);
    go_to(27); chk_eq("glitch_dom_e27", dom_rst, 5'h1e);
               chk_eq("glitch_retries_e27", retries, 0);

    // Mid-release reset with dom_rst = 11000.
    go_to(31); chk_eq("midrst_dom_before", dom_rst, 5'h18);
    rst = 1'b1;
    tick();
    chk_eq("midrst_dom", dom_rst, 5'h1f);
    chk_eq("midrst_pll_rst", pll_rst, 1);
    chk_eq("midrst_state", state, 0);
    chk_eq("midrst_ready", ready, 0);

    // Timeout retry with locked held low.
    locked = 1'b0;
    tick();
    rst = 1'b0;
    e   = -1;
    go_to(35); chk_eq("tmo_pll_rst_e35", pll_rst, 0);
               chk_eq("tmo_retries_e35", retries, 0);
    go_to(36); chk_eq("tmo_pll_rst_e36", pll_rst, 1);
               chk_eq("tmo_retries_e36", retries, 1);
               chk_eq("tmo_state_e36", state, 0);
               chk_eq("tmo_fault_e36", fault, 0);
    locked = 1'b1;
    for (int i = 0; i < 200 && !ready; i++) tick();
    chk_eq("tmo_ready", ready, 1);
    chk_eq("tmo_retries_cleared", retries, 0);
    chk_eq("tmo_dom", dom_rst, 5'h00);

    // Retry exhaustion.
    rst    = 1'b1;
    locked = 1'b0;
    tick();
    rst = 1'b0;
    e   = -1;
`ifdef PLLSEQ_FAULT_EN
    for (int i = 0; i < 400 && state != 3'd5; i++) tick();
    chk_eq("fault_state", state, 5);
    chk_eq("fault_flag", fault, 1);
    chk_eq("fault_pll_rst", pll_rst, 1);
    chk_eq("fault_dom", dom_rst, 5'h1f);
    chk_eq("fault_retries", retries, 3);
    repeat (40) tick();
    chk_eq("fault_hold_state", state, 5);
    chk_eq("fault_hold_pll_rst", pll_rst, 1);
    rst = 1'b1;
    tick();
    chk_eq("fault_clr_flag", fault, 0);
    chk_eq("fault_clr_state", state, 0);
    chk_eq("fault_clr_retries", retries, 0);
    rst = 1'b0;
`else
    for (int i = 0; i < 400 && retries != 4'd4; i++) tick();
    chk_eq("nofault_retries", retries, 4);
    chk_eq("nofault_flag", fault, 0);
    chk_eq("nofault_state", state, 0);
    chk_eq("nofault_pll_rst", pll_rst, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
